wb_trace_buffer: RTL and testbench

//   Records every register-file write leaving the WB stage of the 5-stage cpu into a FIFO.

---
 rtl/wb_trace_buffer.sv | 177 +++++++++++++++++
 tb/tb_wb_trace_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - WB-stage register-write trace FIFO with cycle stamps
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CYC_W  = 12
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              trace_enable,
    input  logic                              trace_clear,
    input  logic                              cpu_halt,
    input  logic                              wb_reg_write,
    input  logic [REG_W-1:0]                  wb_write_reg,
    input  logic [DATA_W-1:0]                 wb_write_data,
    input  logic                              wb_r0_write,
    input  logic [DATA_W-1:0]                 wb_r0_data,
    output logic                              trace_valid,
    input  logic                              trace_ready,
    output logic [CYC_W+1+REG_W+DATA_W-1:0]   trace_data,
    output logic [$clog2(DEPTH):0]            trace_count,
    output logic                              trace_overflow,
    output logic [7:0]                        trace_drops,
    output logic                              trace_frozen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = CYC_W + 1 + REG_W + DATA_W;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_FROZEN   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_frozen;
    logic [CYC_W-1:0] r_cycle;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [7:0]      r_drops;

    logic            w_pop;
    logic            w_capture;
    logic            w_ev_p;
    logic            w_ev_r;
    logic [CW-1:0]   w_free;
    logic            w_acc_p;
    logic            w_acc_r;
    logic [1:0]      w_n_push;
    logic [1:0]      w_n_drop;
    logic [AW-1:0]   w_wr_r_addr;
    logic [EW-1:0]   w_entry_p;
    logic [EW-1:0]   w_entry_r;
    logic [8:0]      w_drops_sum;

    assign w_pop     = (r_count != '0) && trace_ready;
    assign w_capture = (r_state == ST_CAPTURE);
    assign w_ev_p    = w_capture && wb_reg_write;
    assign w_ev_r    = w_capture && wb_r0_write;

    // Slots available this cycle, counting the slot freed by a concurrent pop
    assign w_free  = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_acc_p = w_ev_p && (w_free != '0);
    assign w_acc_r = w_ev_r && (w_acc_p ? (w_free >= CW'(2)) : (w_free != '0));

    assign w_n_push = {1'b0, w_acc_p} + {1'b0, w_acc_r};
    assign w_n_drop = {1'b0, w_ev_p & ~w_acc_p} + {1'b0, w_ev_r & ~w_acc_r};

    // Primary sits nearer the head; R0 goes in the slot after it when both land
    assign w_wr_r_addr = r_wr_ptr + AW'(w_acc_p);
    assign w_entry_p   = {r_cycle, 1'b0, wb_write_reg, wb_write_data};
    assign w_entry_r   = {r_cycle, 1'b1, {REG_W{1'b0}}, wb_r0_data};

    assign w_drops_sum = {1'b0, r_drops} + {7'd0, w_n_drop};

    // Trace control FSM; clear wins over every other transition
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_DISABLED;
            r_frozen <= 1'b0;
        end else if (trace_clear) begin
            r_state  <= ST_DISABLED;
            r_frozen <= 1'b0;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    if (trace_enable) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (cpu_halt) begin
                        r_state  <= ST_FROZEN;
                        r_frozen <= 1'b1;
                    end else if (!trace_enable) begin
                        r_state <= ST_DISABLED;
                    end
                end
                ST_FROZEN: begin
                    r_state  <= ST_FROZEN;
                    r_frozen <= 1'b1;
                end
                default: begin
                    r_state  <= ST_DISABLED;
                    r_frozen <= 1'b0;
                end
            endcase
        end
    end

    // Free-running stamp while tracing is armed or frozen
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else if (trace_clear) begin
            r_cycle <= '0;
        end else if (r_state != ST_DISABLED) begin
            r_cycle <= r_cycle + CYC_W'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clock) begin
        if (!trace_clear) begin
            if (w_acc_p) begin
                r_mem[r_wr_ptr] <= w_entry_p;
            end
            if (w_acc_r) begin
                r_mem[w_wr_r_addr] <= w_entry_r;
            end
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (trace_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
            r_count  <= r_count - CW'(w_pop) + CW'(w_n_push);
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (trace_clear) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (w_n_drop != 2'd0) begin
            r_overflow <= 1'b1;
            r_drops    <= w_drops_sum[8] ? 8'hFF : w_drops_sum[7:0];
        end
    end

    assign trace_valid    = (r_count != '0);
    assign trace_data     = trace_valid ? r_mem[r_rd_ptr] : '0;
    assign trace_count    = r_count;
    assign trace_overflow = r_overflow;
    assign trace_drops    = r_drops;
    assign trace_frozen   = r_frozen;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - directed self-checking bench for wb_trace_buffer
module tb_wb_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        trace_enable;
    logic        trace_clear;
    logic        cpu_halt;
    logic        wb_reg_write;
    logic [3:0]  wb_write_reg;
    logic [15:0] wb_write_data;
    logic        wb_r0_write;
    logic [15:0] wb_r0_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [32:0] trace_data;
    logic [4:0]  trace_count;
    logic        trace_overflow;
    logic [7:0]  trace_drops;
    logic        trace_frozen;

    int n_cmp = 0;
    int n_bad = 0;

    wb_trace_buffer #(.DEPTH(16), .DATA_W(16), .REG_W(4), .CYC_W(12)) dut (
        .clock          (clock),
        .reset          (reset),
        .trace_enable   (trace_enable),
        .trace_clear    (trace_clear),
        .cpu_halt       (cpu_halt),
        .wb_reg_write   (wb_reg_write),
        .wb_write_reg   (wb_write_reg),
        .wb_write_data  (wb_write_data),
        .wb_r0_write    (wb_r0_write),
        .wb_r0_data     (wb_r0_data),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_data     (trace_data),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow),
        .trace_drops    (trace_drops),
        .trace_frozen   (trace_frozen)
    );

    always #5 clock = ~clock;

    function automatic logic [32:0] ent(input logic [11:0] cyc, input logic is_r0,
                                        input logic [3:0] rg, input logic [15:0] d);
        return {cyc, is_r0, rg, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] rg, input logic [15:0] d);
        wb_reg_write  = 1'b1;
        wb_write_reg  = rg;
        wb_write_data = d;
        tick();
        wb_reg_write  = 1'b0;
    endtask

    task automatic dual(input logic [3:0] rg, input logic [15:0] d, input logic [15:0] d0);
        wb_reg_write  = 1'b1;
        wb_write_reg  = rg;
        wb_write_data = d;
        wb_r0_write   = 1'b1;
        wb_r0_data    = d0;
        tick();
        wb_reg_write  = 1'b0;
        wb_r0_write   = 1'b0;
    endtask

    // Clear, then re-arm: the first capture cycle afterwards carries stamp 0
    task automatic restart();
        trace_enable = 1'b1;
        trace_clear  = 1'b1;
        tick();
        trace_clear  = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        trace_enable = 1'b0; trace_clear = 1'b0; cpu_halt = 1'b0;
        wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
        wb_r0_write = 1'b0; wb_r0_data = '0; trace_ready = 1'b0;

        #12;
        check("rst_valid", 64'(trace_valid), 64'd0);
        check("rst_data", 64'(trace_data), 64'd0);
        check("rst_count", 64'(trace_count), 64'd0);
        check("rst_ovf", 64'(trace_overflow), 64'd0);
        check("rst_drops", 64'(trace_drops), 64'd0);
        check("rst_frozen", 64'(trace_frozen), 64'd0);
        reset = 1'b1;

        // 1: single write with stamp 5
        trace_enable = 1'b1;
        trace_ready  = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        wr(4'h3, 16'h00A5);
        check("t1_valid", 64'(trace_valid), 64'd1);
        check("t1_data", 64'(trace_data), 64'(ent(12'd5, 1'b0, 4'h3, 16'h00A5)));
        tick();
        check("t1_valid_after", 64'(trace_valid), 64'd0);

        // 2: dual write, primary then R0, same stamp
        restart();
        dual(4'h2, 16'h1111, 16'h2222);
        check("t2_count", 64'(trace_count), 64'd2);
        check("t2_first", 64'(trace_data), 64'(ent(12'd0, 1'b0, 4'h2, 16'h1111)));
        tick();
        check("t2_second", 64'(trace_data), 64'(ent(12'd0, 1'b1, 4'h0, 16'h2222)));
        tick();
        check("t2_empty", 64'(trace_valid), 64'd0);

        // 3: overflow with 18 writes into 16 slots
        restart();
        trace_ready = 1'b0;
        for (int i = 0; i < 18; i++) wr(4'(i), 16'h3000 + 16'(i));
        check("t3_count", 64'(trace_count), 64'd16);
        check("t3_ovf", 64'(trace_overflow), 64'd1);
        check("t3_drops", 64'(trace_drops), 64'd2);
        tick();
        check("t3_hold", 64'(trace_data), 64'(ent(12'd0, 1'b0, 4'h0, 16'h3000)));
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_drain", 64'(trace_data), 64'(ent(12'(i), 1'b0, 4'(i), 16'h3000 + 16'(i))));
            tick();
        end
        check("t3_drained", 64'(trace_count), 64'd0);

        // 4: one slot left, dual write; then pop-assisted accepts
        restart();
        trace_ready = 1'b0;
        for (int i = 0; i < 15; i++) wr(4'(i), 16'h4000 + 16'(i));
        check("t4_count15", 64'(trace_count), 64'd15);
        dual(4'h5, 16'h5555, 16'h6666);
        check("t4_count16", 64'(trace_count), 64'd16);
        check("t4_drops", 64'(trace_drops), 64'd1);
        check("t4_ovf", 64'(trace_overflow), 64'd1);
        trace_ready = 1'b1;
        tick();
        check("t4_pop", 64'(trace_count), 64'd15);
        dual(4'h6, 16'h8888, 16'h7777);
        check("t4_dual_ok", 64'(trace_count), 64'd16);
        check("t4_drops_kept", 64'(trace_drops), 64'd1);
        wr(4'h9, 16'h9999);
        check("t4_full_popush", 64'(trace_count), 64'd16);
        check("t4_drops_same", 64'(trace_drops), 64'd1);
        check("t4_head", 64'(trace_data), 64'(ent(12'd3, 1'b0, 4'h3, 16'h4003)));
        for (int i = 0; i < 15; i++) tick();
        check("t4_tail", 64'(trace_data), 64'(ent(12'd18, 1'b0, 4'h9, 16'h9999)));
        tick();
        check("t4_empty", 64'(trace_count), 64'd0);

        // 5: halt freezes capture, drain continues, clear returns to disabled
        restart();
        trace_ready = 1'b0;
        wr(4'h1, 16'h0101);
        cpu_halt = 1'b1;
        wr(4'h2, 16'h0202);
        cpu_halt = 1'b0;
        check("t5_frozen", 64'(trace_frozen), 64'd1);
        check("t5_count", 64'(trace_count), 64'd2);
        wr(4'h4, 16'h0404);
        check("t5_ignored", 64'(trace_count), 64'd2);
        trace_enable = 1'b0;
        tick();
        check("t5_still_frozen", 64'(trace_frozen), 64'd1);
        trace_ready = 1'b1;
        check("t5_d0", 64'(trace_data), 64'(ent(12'd0, 1'b0, 4'h1, 16'h0101)));
        tick();
        check("t5_d1", 64'(trace_data), 64'(ent(12'd1, 1'b0, 4'h2, 16'h0202)));
        tick();
        check("t5_drained", 64'(trace_count), 64'd0);
        trace_clear = 1'b1;
        tick();
        trace_clear = 1'b0;
        check("t5_clr_frozen", 64'(trace_frozen), 64'd0);
        check("t5_clr_drops", 64'(trace_drops), 64'd0);
        wr(4'h5, 16'h0505);
        check("t5_disabled", 64'(trace_count), 64'd0);

        // 6: async reset mid-drain
        restart();
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(4'(i), 16'h6000 + 16'(i));
        trace_ready = 1'b1;
        tick();
        check("t6_count7", 64'(trace_count), 64'd7);
        #3 reset = 1'b0;
        #1;
        check("t6_rst_valid", 64'(trace_valid), 64'd0);
        check("t6_rst_count", 64'(trace_count), 64'd0);
        #2 reset = 1'b1;
        tick();
        wr(4'h7, 16'h0777);
        check("t6_restamp", 64'(trace_data), 64'(ent(12'd0, 1'b0, 4'h7, 16'h0777)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
